// File: rtl/x_debounce_if.sv
// Signal bundle between a raw-level source and the x_debounce conditioner.
// The source drives the raw level; the debouncer returns the clean level,
// the one-cycle edge events and the qualification-in-progress flag.
interface x_debounce_if;
    logic din;
    logic x;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output din,
        input  x,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  din,
        output x,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/x_debounce.sv
// x_debounce: conditions a raw, possibly bouncing asynchronous level into a
// clean clock-synchronous level x, plus one-cycle rise/fall events and a
// busy flag. A two-flop synchronizer feeds a four-state debounce FSM that
// only accepts a new level once it has held for STABLE_CYCLES+1 samples.
module x_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic        clk,
    input  logic        rst,
    x_debounce_if.slave dbus
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);

    // The counter must be able to reach STABLE_CYCLES without wrapping.
    generate
        if ((STABLE_CYCLES < 1) || (STABLE_CYCLES > ((2 ** CNT_W) - 1))) begin : g_bad_param
            $error("x_debounce: STABLE_CYCLES must lie in 1..2**CNT_W-1");
        end
    endgenerate

    logic             s1_r;
    logic             s2_r;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             x_r;
    logic             rise_r;
    logic             fall_r;
    logic             busy_r;
    logic             x_s;
    logic             rise_s;
    logic             fall_s;
    logic             busy_s;

    // Two-flop synchronizer; metastability is confined to s1_r.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= dbus.din;
            s2_r <= s1_r;
        end
    end

    // State register, stability counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE_LOW;
            cnt_r   <= CNT_ZERO;
            x_r     <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            x_r     <= x_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
            busy_r  <= busy_s;
        end
    end

    // Next-state and counter: any reversal during a wait falls back to idle.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE_LOW: begin
                if (s2_r) begin
                    state_s = WAIT_HIGH;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = IDLE_LOW;
                    cnt_s   = CNT_ZERO;
                end
            end
            WAIT_HIGH: begin
                if (!s2_r) begin
                    state_s = IDLE_LOW;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_DONE) begin
                    state_s = IDLE_HIGH;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = WAIT_HIGH;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2_r) begin
                    state_s = WAIT_LOW;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = IDLE_HIGH;
                    cnt_s   = CNT_ZERO;
                end
            end
            WAIT_LOW: begin
                if (s2_r) begin
                    state_s = IDLE_HIGH;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_DONE) begin
                    state_s = IDLE_LOW;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = WAIT_LOW;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE_LOW;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the transition about to be taken, so the registered
    // outputs line up with the state they describe.
    always_comb begin
        x_s    = 1'b0;
        rise_s = 1'b0;
        fall_s = 1'b0;
        busy_s = 1'b0;
        if ((state_s == IDLE_HIGH) || (state_s == WAIT_LOW)) begin
            x_s = 1'b1;
        end else begin
            x_s = 1'b0;
        end
        if ((state_s == WAIT_HIGH) || (state_s == WAIT_LOW)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
        if ((state_r == WAIT_HIGH) && (state_s == IDLE_HIGH)) begin
            rise_s = 1'b1;
        end else begin
            rise_s = 1'b0;
        end
        if ((state_r == WAIT_LOW) && (state_s == IDLE_LOW)) begin
            fall_s = 1'b1;
        end else begin
            fall_s = 1'b0;
        end
    end

    assign dbus.x    = x_r;
    assign dbus.rise = rise_r;
    assign dbus.fall = fall_r;
    assign dbus.busy = busy_r;

endmodule

// File: tb/tb_x_debounce.sv
// Bench for x_debounce: two instances (STABLE_CYCLES=4/CNT_W=3 and
// STABLE_CYCLES=1/CNT_W=1) share one raw input. A run-length reference model
// says x flips once the synchronized input has disagreed with x for
// STABLE_CYCLES+1 consecutive edges.
module tb_x_debounce;

    logic clk;
    logic rst;
    logic din;

    x_debounce_if bus0 ();
    x_debounce_if bus1 ();

    assign bus0.din = din;
    assign bus1.din = din;

    x_debounce #(.STABLE_CYCLES(4), .CNT_W(3)) dut0 (.clk(clk), .rst(rst), .dbus(bus0));
    x_debounce #(.STABLE_CYCLES(1), .CNT_W(1)) dut1 (.clk(clk), .rst(rst), .dbus(bus1));

    logic [1:0] ox, orise, ofall, obusy;
    assign ox    = {bus1.x,    bus0.x};
    assign orise = {bus1.rise, bus0.rise};
    assign ofall = {bus1.fall, bus0.fall};
    assign obusy = {bus1.busy, bus0.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state per instance
    int stab[2] = '{4, 1};
    bit p1[2];
    bit p2[2];
    int run[2];
    bit mx[2], mrise[2], mfall[2], mbusy[2];

    // observed event counters
    int nrise[2], nfall[2], nbusy[2], nxhigh[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            p1[i] = 1'b0; p2[i] = 1'b0; run[i] = 0;
            mx[i] = 1'b0; mrise[i] = 1'b0; mfall[i] = 1'b0; mbusy[i] = 1'b0;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            nrise[i] = 0; nfall[i] = 0; nbusy[i] = 0; nxhigh[i] = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_x%0d", tag, i),    ox[i],    1'b0);
            chk($sformatf("%s_rise%0d", tag, i), orise[i], 1'b0);
            chk($sformatf("%s_fall%0d", tag, i), ofall[i], 1'b0);
            chk($sformatf("%s_busy%0d", tag, i), obusy[i], 1'b0);
        end
    endtask

    // one active edge: advance the model, then compare #1 later
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit seen;
            seen = p2[i];
            p2[i] = p1[i];
            p1[i] = din;
            mrise[i] = 1'b0;
            mfall[i] = 1'b0;
            if (seen != mx[i]) begin
                run[i]++;
                if (run[i] == stab[i] + 1) begin
                    mx[i]    = seen;
                    mrise[i] = seen;
                    mfall[i] = !seen;
                    run[i]   = 0;
                end else begin
                    mrise[i] = 1'b0;
                end
            end else begin
                run[i] = 0;
            end
            mbusy[i] = (run[i] != 0);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("x%0d", i),    ox[i],    mx[i]);
            chk($sformatf("rise%0d", i), orise[i], mrise[i]);
            chk($sformatf("fall%0d", i), ofall[i], mfall[i]);
            chk($sformatf("busy%0d", i), obusy[i], mbusy[i]);
            nrise[i]  += int'(orise[i]);
            nfall[i]  += int'(ofall[i]);
            nbusy[i]  += int'(obusy[i]);
            nxhigh[i] += int'(ox[i]);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // edges from the sampling edge until each x reaches lvl (-1 if never)
    task automatic measure(input logic lvl, output int lat0, output int lat1);
        lat0 = -1;
        lat1 = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (ox[0] === lvl && lat0 < 0) lat0 = t - 1;
            if (ox[1] === lvl && lat1 < 0) lat1 = t - 1;
        end
    endtask

    initial begin
        int l0, l1;
        int hold;
        logic lvl;

        // reset with din held high
        rst = 1'b0;
        din = 1'b1;
        reset_model();
        clear_counts();
        #1;
        check_all_zero("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all_zero("rst_hold");
        end
        rst = 1'b1;
        measure(1'b1, l0, l1);
        chk("rst_release_lat0", l0, 6);
        chk("rst_release_lat1", l1, 3);
        chk("rst_release_rise0", nrise[0], 1);
        chk("rst_release_busy0", nbusy[0], 4);

        // clean toggle
        din = 1'b0;
        ticks(10);
        clear_counts();
        din = 1'b1;
        measure(1'b1, l0, l1);
        chk("toggle_rise_lat0", l0, 6);
        chk("toggle_rise_lat1", l1, 3);
        din = 1'b0;
        measure(1'b0, l0, l1);
        chk("toggle_fall_lat0", l0, 6);
        chk("toggle_fall_lat1", l1, 3);
        chk("toggle_nrise0", nrise[0], 1);
        chk("toggle_nfall0", nfall[0], 1);

        // bounce rejection on the slow instance
        clear_counts();
        din = 1'b1; ticks(2);
        din = 1'b0; ticks(1);
        din = 1'b1; ticks(3);
        din = 1'b0; ticks(10);
        chk("bounce_nrise0", nrise[0], 0);
        chk("bounce_xhigh0", nxhigh[0], 0);
        chk("bounce_busy_seen0", (nbusy[0] > 0), 1);

        // bounce then settle high
        clear_counts();
        for (int g = 0; g < 3; g++) begin
            din = 1'b1; ticks(1);
            din = 1'b0; ticks(1);
        end
        din = 1'b1; ticks(15);
        chk("settle_nrise0", nrise[0], 1);
        chk("settle_nfall0", nfall[0], 0);
        din = 1'b0; ticks(10);

        // reset while qualifying a rise with cnt=3
        din = 1'b1;
        for (int g = 0; g < 10 && run[0] != 3; g++) tick();
        chk("midq_busy_pre", obusy[0], 1'b1);
        #3;
        rst = 1'b0;
        reset_model();
        #1;
        check_all_zero("midq_async");
        @(posedge clk);
        #1;
        check_all_zero("midq_hold");
        rst = 1'b1;
        measure(1'b1, l0, l1);
        chk("midq_lat0", l0, 6);

        // 2-cycle pulse: fast instance follows it, slow one ignores it
        din = 1'b0; ticks(10);
        clear_counts();
        din = 1'b1; ticks(2);
        din = 1'b0; ticks(12);
        chk("pulse_xhigh1", nxhigh[1], 2);
        chk("pulse_nrise1", nrise[1], 1);
        chk("pulse_nfall1", nfall[1], 1);
        chk("pulse_nrise0", nrise[0], 0);

        // randomized hold lengths, model-checked every edge
        lvl = 1'b0;
        for (int r = 0; r < 60; r++) begin
            lvl = ~lvl;
            din = lvl;
            hold = int'($urandom_range(1, 8));
            ticks(hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
